fp32_accumulator: RTL and testbench
===================================

# fp32_accumulator

Streaming single-precision accumulator that sums a packet of IEEE-754 FP32 operands into one result. It sits directly upstream of the combinational `Addition_Subtraction` unit: it instantiates that unit once, feeds the registered running sum as one operand and each input beat as the other, and registers the returned result. A per-beat add/subtract select is provided. The final sum is presented on a valid/ready output when the beat flagged `in_last` has been absorbed.

## Interface
- `CNT_W`, default 16: width of the element counter and `out_count`.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  32  FP32 operand.
- `in_sub`  in  1  1 = subtract `in_data` from the sum; 0 = add it.
- `in_last`  in  1  beat is the last beat of the packet.
- `out_valid`  out  1  `out_sum` holds a completed packet result.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  32  accumulated FP32 sum.
- `out_exception`  out  1  sticky flag; set if any beat or result in the packet had exponent 255.
- `out_count`  out  CNT_W  beats in the packet, saturating. Present only with `FP_ACC_COUNT_EN`.

## Operation
- States:
  - `IDLE`: waiting for the first beat.
  - `ACCUM`: mid-packet.
  - `DONE`: result held.
- A beat is accepted when `in_valid & in_ready`. `in_ready = (state != DONE)`.
- First beat, accepted in `IDLE`:
  - `acc <= in_sub ? {~in_data[31], in_data[30:0]} : in_data`. It is loaded directly and does not pass through the adder.
  - `exc <= &in_data[30:23]`.
  - `cnt <= 1`.
- Subsequent beat, accepted in `ACCUM`:
  - Adder inputs: `a = acc`, `b = in_data`, `add_sub_signal = ~in_sub`.
  - `acc <= res`.
  - `exc <= exc | exception`.
  - `cnt <= cnt + 1`, saturating at all-ones.
- The adder returns 0 on exception. `acc` takes that 0, and accumulation continues from 0.
- Transitions:
  - `IDLE` → `ACCUM` on an accepted beat with `in_last = 0`.
  - `IDLE` → `DONE` on an accepted beat with `in_last = 1` (single-beat packet).
  - `ACCUM` → `DONE` on an accepted beat with `in_last = 1`.
  - `DONE` → `IDLE` on `out_valid & out_ready`. `exc` and `cnt` clear on this transition. `acc` is don't-care until the next first-beat load.
- `in_valid` in `DONE` is ignored; the beat stalls upstream.
- `out_sum = acc`, `out_exception = exc`, `out_count = cnt`, `out_valid = (state == DONE)`. All outputs are registered or state-decoded; none is combinational from `in_*`.
- Denormals, rounding, sign of zero: inherited unchanged from the adder (hidden bit 0 when exponent is 0; truncation, no rounding).

## Timing
- Reset values: state `IDLE`, `acc = 0`, `exc = 0`, `cnt = 0`, `out_valid = 0`, `out_sum = 0`, `out_exception = 0`, `out_count = 0`, `in_ready = 1`.
- Throughput: one beat per cycle within a packet. The adder path is combinational, so it is a single-cycle path from `acc`/`in_data` back to `acc`.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Inter-packet gap:
  - `in_ready` is 0 for every `DONE` cycle.
  - The first beat of the next packet is accepted no earlier than the cycle after the output handshake.
- `out_sum`/`out_valid` stay stable while `out_valid & ~out_ready`.
- `rst` asserted mid-packet or in `DONE`: immediate return to reset values. The partial packet is discarded and no output is produced.

## Configuration
- `FP_ACC_COUNT_EN` defined: `cnt` register and `out_count` port exist; `cnt` behaves as in Operation.
- `FP_ACC_COUNT_EN` not defined: `cnt` and `out_count` are absent; all other behaviour and timing are identical.

## Test plan
- Single-beat packet: `in_data = 0x3F800000`, `in_last = 1`, `in_sub = 0`.
  - Next cycle: `out_valid = 1`, `out_sum = 0x3F800000`, `out_count = 1`, `out_exception = 0`.
- Add then subtract: beats 0x3F800000, 0x40000000, then 0x3F800000 with `in_sub = 1` and `in_last = 1`, on consecutive cycles.
  - `out_sum = 0x40000000`, `out_count = 3`.
  - `out_valid` rises the cycle after beat 3.
- First beat subtracted: 0x3FC00000 with `in_sub = 1`, `in_last = 1`.
  - `out_sum = 0xBFC00000`.
- Exception: beats 0x40400000, 0x7F800000, then 0x3F000000 with `in_last = 1`.
  - `out_exception = 1`, `out_sum = 0x3F000000`.
- Backpressure: hold `out_ready = 0` for 5 cycles in `DONE` while `in_valid = 1`.
  - `in_ready = 0` throughout; `out_sum` stable; no beat consumed.
  - Raise `out_ready`: next packet's first beat is accepted the following cycle.
- Reset mid-packet: assert `rst` after 2 of 4 beats, then send one beat 0x40000000 with `in_last = 1`.
  - `out_sum = 0x40000000`, `out_count = 1`, `out_exception = 0`.

Source files
------------

// File: rtl/fp32_accumulator.sv
// Streaming FP32 packet accumulator built around a combinational add/subtract unit.
// Optional beat counter and out_count port are enabled by defining FP_ACC_COUNT_EN.

module Addition_Subtraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_sub_signal,
    output logic        exception,
    output logic [31:0] res
);
    logic        b_eff_sign;
    logic        a_is_larger;
    logic        same_sign;
    logic        op_exc;
    logic        ovf;
    logic [7:0]  exp_l;
    logic [7:0]  exp_s;
    logic [7:0]  shift;
    logic        sign_l;
    logic [23:0] sig_l;
    logic [23:0] sig_s;
    logic [23:0] sig_s_al;
    logic [24:0] sum25;
    logic [23:0] diff;
    logic [4:0]  lz;
    logic [22:0] mant_norm;
    logic        res_sign;
    logic [7:0]  res_exp;
    logic [22:0] res_mant;

    always_comb begin
        b_eff_sign  = b[31] ^ ~add_sub_signal;
        a_is_larger = a[30:0] >= b[30:0];
        exp_l       = a_is_larger ? a[30:23] : b[30:23];
        exp_s       = a_is_larger ? b[30:23] : a[30:23];
        sign_l      = a_is_larger ? a[31] : b_eff_sign;
        // Hidden bit is only present for non-zero exponents.
        sig_l       = a_is_larger ? {|a[30:23], a[22:0]} : {|b[30:23], b[22:0]};
        sig_s       = a_is_larger ? {|b[30:23], b[22:0]} : {|a[30:23], a[22:0]};
        shift       = exp_l - exp_s;
        sig_s_al    = sig_s >> shift;
        same_sign   = (a[31] == b_eff_sign);
        op_exc      = (&a[30:23]) | (&b[30:23]);
        sum25       = {1'b0, sig_l} + {1'b0, sig_s_al};
        diff        = sig_l - sig_s_al;

        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (diff[i]) lz = 5'(23 - i);
        end
        mant_norm = 23'(diff << lz);

        ovf      = 1'b0;
        res_sign = 1'b0;
        res_exp  = 8'd0;
        res_mant = 23'd0;
        if (same_sign) begin
            res_sign = sign_l;
            if (sum25[24]) begin
                ovf      = (exp_l == 8'd254);
                res_exp  = exp_l + 8'd1;
                res_mant = sum25[23:1];
            end else begin
                res_exp  = exp_l;
                res_mant = sum25[22:0];
            end
        end else if ((diff != 24'd0) && (exp_l > {3'b000, lz})) begin
            // Results that would need an exponent below 1 flush to +0.
            res_sign = sign_l;
            res_exp  = exp_l - {3'b000, lz};
            res_mant = mant_norm;
        end

        exception = op_exc | ovf;
        res       = exception ? 32'd0 : {res_sign, res_exp, res_mant};
    end
endmodule

// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACCUM | mid-packet, adding beats into the running sum
// DONE  | result held on the output until handshaken
module fp32_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_exception
`ifdef FP_ACC_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic        exc_q, exc_d;
    logic [31:0] add_res;
    logic        add_exc;
    logic        beat;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    Addition_Subtraction u_add_sub (
        .a              (acc_q),
        .b              (in_data),
        .add_sub_signal (~in_sub),
        .exception      (add_exc),
        .res            (add_res)
    );

    assign in_ready      = (state_q != DONE);
    assign out_valid     = (state_q == DONE);
    assign out_sum       = acc_q;
    assign out_exception = exc_q;
    assign beat          = in_valid & in_ready;

`ifdef FP_ACC_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            IDLE:    if (beat) cnt_d = CNT_W'(1);
            ACCUM:   if (beat && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
            DONE:    if (out_ready) cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign out_count = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                // First beat bypasses the adder; subtraction is a sign flip.
                if (beat) begin
                    acc_d   = in_sub ? {~in_data[31], in_data[30:0]} : in_data;
                    exc_d   = &in_data[30:23];
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = add_res;
                    exc_d   = exc_q | add_exc;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    exc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            exc_q   <= exc_d;
        end
    end
endmodule

// File: tb/tb_fp32_accumulator.sv
// Self-checking bench for fp32_accumulator: directed cases plus randomized integer-valued packets
// checked against an exact arithmetic model.

module tb_fp32_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_sub = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_exception;
`ifdef FP_ACC_COUNT_EN
    logic [15:0] out_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pkt_data[$];
    logic        pkt_sub[$];

    fp32_accumulator #(.CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sub        (in_sub),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_exception (out_exception)
`ifdef FP_ACC_COUNT_EN
        ,
        .out_count     (out_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact FP32 encoding of a small integer.
    function automatic logic [31:0] int_to_fp32(input int v);
        int          m;
        int          p;
        logic [31:0] r;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic send_packet(input int gap_max);
        for (int i = 0; i < pkt_data.size(); i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            in_valid = 1'b0;
            repeat (g) step();
            in_valid = 1'b1;
            in_data  = pkt_data[i];
            in_sub   = pkt_sub[i];
            in_last  = (i == pkt_data.size() - 1);
            check_eq("in_ready_beat", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic expect_result(input logic [31:0] exp_sum, input logic exp_exc,
                                 input int exp_cnt, input int hold);
        check_eq("out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("out_sum", out_sum, exp_sum);
        check_eq("out_exception", {31'd0, out_exception}, {31'd0, exp_exc});
`ifdef FP_ACC_COUNT_EN
        check_eq("out_count", {16'd0, out_count}, 32'(exp_cnt));
`else
        if (exp_cnt < 0) check_eq("exp_cnt_sign", 32'(exp_cnt), 32'd0);
`endif
        repeat (hold) begin
            step();
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_sum", out_sum, exp_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("valid_after_hs", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic load(input logic [31:0] d, input logic s);
        pkt_data.push_back(d);
        pkt_sub.push_back(s);
    endtask

    initial begin
        repeat (2) step();
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_sum", out_sum, 32'd0);
        check_eq("rst_exc", {31'd0, out_exception}, 32'd0);
`ifdef FP_ACC_COUNT_EN
        check_eq("rst_count", {16'd0, out_count}, 32'd0);
`endif
        rst = 1'b0;
        step();

        pkt_data = {}; pkt_sub = {};
        load(32'h3F80_0000, 1'b0);
        send_packet(0);
        expect_result(32'h3F80_0000, 1'b0, 1, 0);

        pkt_data = {}; pkt_sub = {};
        load(32'h3F80_0000, 1'b0);
        load(32'h4000_0000, 1'b0);
        load(32'h3F80_0000, 1'b1);
        send_packet(0);
        expect_result(32'h4000_0000, 1'b0, 3, 0);

        pkt_data = {}; pkt_sub = {};
        load(32'h3FC0_0000, 1'b1);
        send_packet(0);
        expect_result(32'hBFC0_0000, 1'b0, 1, 0);

        pkt_data = {}; pkt_sub = {};
        load(32'h4040_0000, 1'b0);
        load(32'h7F80_0000, 1'b0);
        load(32'h3F00_0000, 1'b0);
        send_packet(0);
        expect_result(32'h3F00_0000, 1'b1, 3, 0);

        // Backpressure while the next packet's beat waits upstream.
        pkt_data = {}; pkt_sub = {};
        load(32'h4080_0000, 1'b0);
        send_packet(0);
        in_valid = 1'b1;
        in_data  = 32'h40A0_0000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_out_sum", out_sum, 32'h4080_0000);
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result(32'h40A0_0000, 1'b0, 1, 0);

        // Reset after 2 of 4 beats discards the partial packet.
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'h4040_0000;
        step();
        in_data  = 32'h7F80_0000;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_sum", out_sum, 32'd0);
        check_eq("mid_rst_exc", {31'd0, out_exception}, 32'd0);
        step();
        rst = 1'b0;
        step();
        pkt_data = {}; pkt_sub = {};
        load(32'h4000_0000, 1'b0);
        send_packet(0);
        expect_result(32'h4000_0000, 1'b0, 1, 0);

        // Random integer-valued packets, occasionally containing Inf/NaN beats.
        for (int p = 0; p < 40; p++) begin
            int          len;
            int          sum;
            logic        special;
            logic [31:0] special_bits;
            logic        exc;
            logic [31:0] exp_sum;
            len = int'($urandom_range(8, 1));
            pkt_data = {}; pkt_sub = {};
            sum = 0; special = 1'b0; special_bits = 32'd0; exc = 1'b0;
            for (int i = 0; i < len; i++) begin
                logic [31:0] d;
                logic        s;
                logic        is_special;
                int          mag;
                int          contrib;
                s = 1'($urandom_range(1, 0));
                is_special = ($urandom_range(7, 0) == 0);
                if (is_special) begin
                    case ($urandom_range(2, 0))
                        0:       d = 32'h7F80_0000;
                        1:       d = 32'hFF80_0000;
                        default: d = 32'h7FC0_0000;
                    endcase
                    exc = 1'b1;
                    if (i == 0) begin
                        special      = 1'b1;
                        special_bits = s ? {~d[31], d[30:0]} : d;
                    end else begin
                        special = 1'b0;
                        sum     = 0;
                    end
                end else begin
                    mag = int'($urandom_range(64, 1));
                    if ($urandom_range(1, 0) == 1) mag = -mag;
                    d = int_to_fp32(mag);
                    contrib = s ? -mag : mag;
                    if (i == 0) begin
                        sum = contrib;
                    end else if (special) begin
                        special = 1'b0;
                        sum     = 0;
                    end else begin
                        sum = sum + contrib;
                    end
                end
                load(d, s);
            end
            exp_sum = special ? special_bits : int_to_fp32(sum);
            send_packet(2);
            expect_result(exp_sum, exc, len, int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
